branch_resolve_ctrl: RTL

//  Sequences ID-stage branch resolution in the 5-stage MIPS pipeline. Detects RAW hazards between
//  the branch operands and in-flight EX/MEM writers, stalls PC/IF-ID for the required cycles, then

---
 rtl/branch_resolve_ctrl_pkg.sv | 35 +++
 rtl/branch_resolve_ctrl_if.sv | 40 ++++
 rtl/branch_resolve_ctrl_stats.sv | 18 +
 rtl/branch_resolve_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for the ID-stage branch resolution controller:
// branch command codes, FSM states and the RAW stall-depth helper.
package branch_resolve_ctrl_pkg;

   typedef enum logic [1:0] {
      COND_NONE = 2'b00,
      COND_JUMP = 2'b01,
      COND_BEQ  = 2'b10,
      COND_BNE  = 2'b11
   } branch_cmd_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STALL   = 2'd1,
      S_RESOLVE = 2'd2
   } state_e;

   // Cycles the branch must wait before its operands are usable in ID.
   // A load in EX needs two cycles; an ALU result in EX or a load in MEM
   // needs one. An ALU result already in MEM is forwarded and costs nothing.
   function automatic logic [1:0] stall_need(input logic ex_wb_en,
                                             input logic ex_load,
                                             input logic ex_match,
                                             input logic mem_wb_en,
                                             input logic mem_load,
                                             input logic mem_match);
      logic [1:0] n;
      n = 2'd0;
      if (mem_wb_en && mem_load && mem_match) n = 2'd1;
      if (ex_wb_en && ex_match)               n = 2'd1;
      if (ex_wb_en && ex_load && ex_match)    n = 2'd2;
      return n;
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Pipeline-side signal bundle of the branch resolution controller.
interface branch_resolve_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int STAT_W     = 16
);
   logic [1:0]            id_branch_cmd;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  ex_wb_en;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_dest;
   logic                  mem_wb_en;
   logic                  mem_mem_read;
   logic [REG_ADDR_W-1:0] mem_dest;
   logic                  branch_cond;
   logic                  pc_write_en;
   logic                  ifid_write_en;
   logic                  idex_bubble;
   logic                  pc_src_sel;
   logic                  ifid_flush;
   logic [STAT_W-1:0]     stat_branches;
   logic [STAT_W-1:0]     stat_taken;
   logic [STAT_W-1:0]     stat_stalls;

   modport master (
      output id_branch_cmd, id_rs, id_rt,
      output ex_wb_en, ex_mem_read, ex_dest,
      output mem_wb_en, mem_mem_read, mem_dest, branch_cond,
      input  pc_write_en, ifid_write_en, idex_bubble, pc_src_sel, ifid_flush,
      input  stat_branches, stat_taken, stat_stalls
   );

   modport slave (
      input  id_branch_cmd, id_rs, id_rt,
      input  ex_wb_en, ex_mem_read, ex_dest,
      input  mem_wb_en, mem_mem_read, mem_dest, branch_cond,
      output pc_write_en, ifid_write_en, idex_bubble, pc_src_sel, ifid_flush,
      output stat_branches, stat_taken, stat_stalls
   );
endinterface

// File: rtl/branch_resolve_ctrl_stats.sv
// Single saturating event counter used for branch statistics.
module branch_stats_counter #(
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   output logic [STAT_W-1:0] count
);
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      count <= '0;
      else if (inc) count <= sat_inc(count);
   end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch hazard stall / resolve sequencer.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int STAT_W     = 16
) (
   input logic                  clk,
   input logic                  rst,
   branch_resolve_ctrl_if.slave bus
);
   state_e      state, state_n;
   logic [1:0]  cnt, cnt_n;
   logic [1:0]  need;
   logic        is_cond, ex_match, mem_match;
   logic        stall, resolve, taken;
   branch_cmd_e cmd;

   assign cmd     = branch_cmd_e'(bus.id_branch_cmd);
   assign is_cond = (cmd == COND_BEQ) || (cmd == COND_BNE);

   // r0 is hard-wired to zero, so writes to it never create a dependency.
   assign ex_match  = (bus.ex_dest != {REG_ADDR_W{1'b0}}) &&
                      ((bus.ex_dest == bus.id_rs) || (bus.ex_dest == bus.id_rt));
   assign mem_match = (bus.mem_dest != {REG_ADDR_W{1'b0}}) &&
                      ((bus.mem_dest == bus.id_rs) || (bus.mem_dest == bus.id_rt));

   assign need = is_cond ? stall_need(bus.ex_wb_en, bus.ex_mem_read, ex_match,
                                      bus.mem_wb_en, bus.mem_mem_read, mem_match)
                         : 2'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      stall   = 1'b0;
      resolve = 1'b0;
      taken   = 1'b0;
      case (state)
         S_IDLE: begin
            if (is_cond && (need != 2'd0)) begin
               stall   = 1'b1;
               cnt_n   = need - 2'd1;
               state_n = (need == 2'd1) ? S_RESOLVE : S_STALL;
            end else if (is_cond) begin
               resolve = 1'b1;
               taken   = bus.branch_cond;
            end else if (cmd == COND_JUMP) begin
               resolve = 1'b1;
               taken   = 1'b1;
            end
         end
         S_STALL: begin
            stall   = 1'b1;
            cnt_n   = cnt - 2'd1;
            state_n = (cnt == 2'd1) ? S_RESOLVE : S_STALL;
         end
         S_RESOLVE: begin
            // Operands are ready now; hazard inputs belong to younger instructions.
            resolve = 1'b1;
            taken   = bus.branch_cond;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.pc_write_en   = ~stall;
   assign bus.ifid_write_en = ~stall;
   assign bus.idex_bubble   = stall;
   assign bus.pc_src_sel    = resolve & taken;
   assign bus.ifid_flush    = resolve & taken;

`ifdef BRANCH_STATS_EN
   branch_stats_counter #(.STAT_W(STAT_W)) u_stat_branches (
      .clk(clk), .rst(rst), .inc(resolve), .count(bus.stat_branches));
   branch_stats_counter #(.STAT_W(STAT_W)) u_stat_taken (
      .clk(clk), .rst(rst), .inc(resolve & taken), .count(bus.stat_taken));
   branch_stats_counter #(.STAT_W(STAT_W)) u_stat_stalls (
      .clk(clk), .rst(rst), .inc(stall), .count(bus.stat_stalls));
`else
   assign bus.stat_branches = {STAT_W{1'b0}};
   assign bus.stat_taken    = {STAT_W{1'b0}};
   assign bus.stat_stalls   = {STAT_W{1'b0}};
`endif

endmodule
